// File: rtl/elevator_ctrl_nfloor.sv
// elevator_ctrl_nfloor
// Single-cab controller for NB_FLOORS floors. Calls are latched into a pending
// vector and served in SCAN (collective) order: the cab keeps its direction
// while requests remain ahead of it and reverses only from IDLE. Door opening
// and inter-floor travel are timed with down-counters. The FSM state is
// exported on state_o (IDLE=0, OPEN=1, MOVE=2) so property checkers can bind
// to it. Calls are plain level inputs sampled on every rising edge; there is
// no handshake, a call is simply held in pending_o until the door opens at
// that floor.
module elevator_ctrl_nfloor #(
    parameter int NB_FLOORS     = 4,
    parameter int DOOR_CYCLES   = 10,
    parameter int TRAVEL_CYCLES = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NB_FLOORS-1:0]         call_i,
    output logic [NB_FLOORS-1:0]         floor_o,
    output logic [$clog2(NB_FLOORS)-1:0] pos_o,
    output logic                         open_o,
    output logic                         moving_o,
    output logic                         dir_up_o,
    output logic [NB_FLOORS-1:0]         pending_o,
    output logic [1:0]                   state_o
);

    localparam int PW = $clog2(NB_FLOORS);
    localparam int DW = $clog2(DOOR_CYCLES + 1);
    localparam int TW = $clog2(TRAVEL_CYCLES + 1);

    localparam logic [NB_FLOORS-1:0] ONE         = NB_FLOORS'(1);
    localparam logic [PW-1:0]        POS_TOP     = PW'(NB_FLOORS - 1);
    // Counters are loaded with N-1 so the entry edge counts as the first cycle.
    localparam logic [DW-1:0]        DOOR_LOAD   = DW'(DOOR_CYCLES - 1);
    localparam logic [TW-1:0]        TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OPEN = 2'd1,
        ST_MOVE = 2'd2
    } state_t;

    state_t               r_state;
    logic [PW-1:0]        r_pos;
    logic                 r_dir_up;
    logic [NB_FLOORS-1:0] r_pending;
    logic [DW-1:0]        r_door_cnt;
    logic [TW-1:0]        r_travel_cnt;

    state_t               w_state_nxt;
    logic [PW-1:0]        w_pos_nxt;
    logic                 w_dir_nxt;
    logic [NB_FLOORS-1:0] w_pending_nxt;
    logic [DW-1:0]        w_door_nxt;
    logic [TW-1:0]        w_travel_nxt;

    logic [NB_FLOORS-1:0] w_req;
    logic [NB_FLOORS-1:0] w_clear;
    logic [NB_FLOORS-1:0] w_pos_oh;
    logic [PW-1:0]        w_seg_pos;
    logic [NB_FLOORS-1:0] w_seg_oh;
    logic [NB_FLOORS-1:0] w_above_pos;
    logic [NB_FLOORS-1:0] w_below_pos;
    logic [NB_FLOORS-1:0] w_above_seg;
    logic [NB_FLOORS-1:0] w_below_seg;
    logic                 w_ahead_pos;
    logic                 w_behind_pos;
    logic                 w_ahead_seg;

    // Floor decoding: current floor, floor reached at the end of the
    // current segment (clamped to the shaft), and above/below masks for both.
    always_comb begin
        w_pos_oh  = ONE << r_pos;
        w_seg_pos = r_pos;
        if (r_dir_up && (r_pos != POS_TOP)) begin
            w_seg_pos = r_pos + PW'(1);
        end else if (!r_dir_up && (r_pos != '0)) begin
            w_seg_pos = r_pos - PW'(1);
        end
        w_seg_oh    = ONE << w_seg_pos;
        w_above_pos = '0;
        w_below_pos = '0;
        w_above_seg = '0;
        w_below_seg = '0;
        for (int k = 0; k < NB_FLOORS; k++) begin
            w_above_pos[k] = (k > int'(r_pos));
            w_below_pos[k] = (k < int'(r_pos));
            w_above_seg[k] = (k > int'(w_seg_pos));
            w_below_seg[k] = (k < int'(w_seg_pos));
        end
    end

    // Request summary: a same-edge call counts as much as a latched one.
    always_comb begin
        w_req        = r_pending | call_i;
        w_ahead_pos  = r_dir_up ? |(w_req & w_above_pos) : |(w_req & w_below_pos);
        w_behind_pos = r_dir_up ? |(w_req & w_below_pos) : |(w_req & w_above_pos);
        w_ahead_seg  = r_dir_up ? |(w_req & w_above_seg) : |(w_req & w_below_seg);
    end

    // Next-state logic: SCAN scheduling, door timer and travel timer.
    always_comb begin
        w_state_nxt  = r_state;
        w_pos_nxt    = r_pos;
        w_dir_nxt    = r_dir_up;
        w_door_nxt   = r_door_cnt;
        w_travel_nxt = r_travel_cnt;
        w_clear      = '0;
        case (r_state)
            ST_IDLE: begin
                if (|(w_req & w_pos_oh)) begin
                    w_state_nxt = ST_OPEN;
                    w_door_nxt  = DOOR_LOAD;
                    w_clear     = w_pos_oh;
                end else if (w_ahead_pos) begin
                    w_state_nxt  = ST_MOVE;
                    w_travel_nxt = TRAVEL_LOAD;
                end else if (w_behind_pos) begin
                    // Reversal happens only here, on the same edge as departure.
                    w_dir_nxt    = ~r_dir_up;
                    w_state_nxt  = ST_MOVE;
                    w_travel_nxt = TRAVEL_LOAD;
                end
            end
            ST_OPEN: begin
                // A call at the open floor is absorbed: it only holds the door.
                w_clear = w_pos_oh;
                if (|(call_i & w_pos_oh)) begin
                    w_door_nxt = DOOR_LOAD;
                end else if (r_door_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_door_nxt = r_door_cnt - DW'(1);
                end
            end
            ST_MOVE: begin
                if (r_travel_cnt == '0) begin
                    w_pos_nxt = w_seg_pos;
                    if (|(w_req & w_seg_oh)) begin
                        w_state_nxt = ST_OPEN;
                        w_door_nxt  = DOOR_LOAD;
                        w_clear     = w_seg_oh;
                    end else if (w_ahead_seg) begin
                        w_travel_nxt = TRAVEL_LOAD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_travel_nxt = r_travel_cnt - TW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_pending_nxt = w_req & ~w_clear;
    end

    // State register; reset returns the cab to floor 0 wherever it was.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_pos        <= '0;
            r_dir_up     <= 1'b1;
            r_pending    <= '0;
            r_door_cnt   <= '0;
            r_travel_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pos        <= w_pos_nxt;
            r_dir_up     <= w_dir_nxt;
            r_pending    <= w_pending_nxt;
            r_door_cnt   <= w_door_nxt;
            r_travel_cnt <= w_travel_nxt;
        end
    end

    assign floor_o   = (r_state == ST_MOVE) ? '0 : w_pos_oh;
    assign pos_o     = r_pos;
    assign open_o    = (r_state == ST_OPEN);
    assign moving_o  = (r_state == ST_MOVE);
    assign dir_up_o  = r_dir_up;
    assign pending_o = r_pending;
    assign state_o   = r_state;

endmodule

// File: tb/tb_elevator_ctrl_nfloor.sv
// Bench for elevator_ctrl_nfloor (4 floors, 10-cycle door, 4-cycle segment).
// Stimulus pushes one expected record per door opening; the monitor pops it
// when the door closes and compares floor, pending calls, direction at the
// opening and the open duration. Cycle-exact checks cover reset and the
// single-call timing.
module tb_elevator_ctrl_nfloor;

  localparam int NB = 4;
  localparam int DC = 10;
  localparam int TC = 4;
  localparam int W  = 32;

  logic          clk;
  logic          rst;
  logic [NB-1:0] call;
  logic [NB-1:0] floor_o;
  logic [1:0]    pos_o;
  logic          open_o;
  logic          moving_o;
  logic          dir_up_o;
  logic [NB-1:0] pending_o;
  logic [1:0]    state_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic mon_en = 1'b0;

  elevator_ctrl_nfloor #(
    .NB_FLOORS(NB),
    .DOOR_CYCLES(DC),
    .TRAVEL_CYCLES(TC)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .call_i(call),
    .floor_o(floor_o),
    .pos_o(pos_o),
    .open_o(open_o),
    .moving_o(moving_o),
    .dir_up_o(dir_up_o),
    .pending_o(pending_o),
    .state_o(state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // record layout: {pending at first open cycle, floor, open cycles, dir}
  function automatic logic [W-1:0] mk_exp(input int pend, input int pos, input int dur, input int dir);
    return {8'(pend), 8'(pos), 8'(dur), 8'(dir)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_floor"}, 32'(floor_o), 32'h1);
    chk({name, "_pos"}, 32'(pos_o), 32'h0);
    chk({name, "_open"}, 32'(open_o), 32'h0);
    chk({name, "_moving"}, 32'(moving_o), 32'h0);
    chk({name, "_dir"}, 32'(dir_up_o), 32'h1);
    chk({name, "_pending"}, 32'(pending_o), 32'h0);
  endtask

  // wait until every expected opening is seen and the cab is idle
  task automatic wait_drain(input string name);
    int cyc = 0;
    while ((exp_q.size() != 0 || open_o || moving_o) && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc >= 400) begin
      n_fail++;
      $display("FAIL %s_drain: %0d openings still outstanding after %0d cycles, expected 0", name, exp_q.size(), cyc);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  // monitor: invariants every cycle, one scoreboard pop per door closing
  logic          mon_prev_open = 1'b0;
  logic [NB-1:0] mon_pend;
  logic [1:0]    mon_pos;
  logic          mon_dir;
  int            mon_dur = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      logic inv_ok;
      logic [W-1:0] act;
      logic [W-1:0] exp;
      inv_ok = $onehot0(floor_o) && !(open_o && moving_o) &&
               (!open_o || (floor_o == (NB'(1) << pos_o))) &&
               (!moving_o || (floor_o == '0));
      chk("invariants", 32'(inv_ok), 32'h1);
      if (rst) begin
        mon_prev_open = 1'b0;
        mon_dur = 0;
      end else if (open_o && !mon_prev_open) begin
        mon_pend = pending_o;
        mon_pos  = pos_o;
        mon_dir  = dir_up_o;
        mon_dur  = 1;
      end else if (open_o) begin
        mon_dur++;
      end else if (mon_prev_open) begin
        act = {8'(mon_pend), 8'(mon_pos), 8'(mon_dur), 8'(mon_dir)};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_open: got opening %0h, expected none", act);
        end else begin
          exp = exp_q.pop_front();
          if (act !== exp) begin
            n_fail++;
            $display("FAIL opening: got pend=%0h floor=%0d dur=%0d dir=%0d, expected pend=%0h floor=%0d dur=%0d dir=%0d",
                     act[31:24], act[23:16], act[15:8], act[7:0],
                     exp[31:24], exp[23:16], exp[15:8], exp[7:0]);
          end
        end
      end
      mon_prev_open = rst ? 1'b0 : open_o;
    end
  end

  // stimulus
  initial begin
    int e_pos;
    logic e_mov;
    logic e_open;
    rst  = 1'b1;
    call = NB'($urandom_range(0, 15));

    // power-up reset with random calls on the inputs
    repeat (2) begin
      @(negedge clk);
      call = NB'($urandom_range(0, 15));
    end
    @(negedge clk);
    chk_reset("rst_held");
    rst  = 1'b0;
    call = '0;
    mon_en = 1'b1;
    @(negedge clk);
    chk_reset("rst_release");

    // single call up to floor 2, cycle-exact
    call = 4'b0100;
    exp_q.push_back(mk_exp(0, 2, 10, 1));
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) call = '0;
      e_mov  = (c >= 1 && c <= 8);
      e_pos  = (c <= 4) ? 0 : ((c <= 8) ? 1 : 2);
      e_open = (c >= 9 && c <= 18);
      chk("up_moving", 32'(moving_o), 32'(e_mov));
      chk("up_pos", 32'(pos_o), 32'(e_pos));
      chk("up_open", 32'(open_o), 32'(e_open));
      chk("up_floor", 32'(floor_o), e_mov ? 32'h0 : (32'h1 << e_pos));
      if (c == 3) chk("up_pending_move", 32'(pending_o), 32'h4);
      if (c == 19) chk("up_pending_done", 32'(pending_o), 32'h0);
    end
    wait_drain("single_up");

    // hold-open: reload on the edge that starts the 8th open cycle
    call = 4'b0100;
    exp_q.push_back(mk_exp(0, 2, 17, 1));
    @(negedge clk);
    call = '0;
    repeat (6) @(negedge clk);
    call = 4'b0100;
    @(negedge clk);
    call = '0;
    chk("hold_pending", 32'(pending_o), 32'h0);
    wait_drain("hold_open");

    // reset during travel from floor 2 down to floor 0
    call = 4'b0001;
    @(negedge clk);
    call = '0;
    repeat (5) @(negedge clk);
    chk("mid_move_moving", 32'(moving_o), 32'h1);
    chk("mid_move_pos", 32'(pos_o), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset("rst_move");
    @(negedge clk);
    chk_reset("rst_move_after");

    // SCAN: floor 3 served before floor 0, no stops when passing
    call = 4'b1000;
    exp_q.push_back(mk_exp(4'b0001, 3, 10, 1));
    exp_q.push_back(mk_exp(0, 0, 10, 0));
    @(negedge clk);
    call = 4'b0001;
    @(negedge clk);
    call = '0;
    wait_drain("scan");
    chk("scan_dir_after", 32'(dir_up_o), 32'h0);

    // passing stop: call 2 latched one edge before the floor-2 segment end
    call = 4'b1000;
    exp_q.push_back(mk_exp(4'b1000, 2, 10, 1));
    exp_q.push_back(mk_exp(0, 3, 10, 1));
    @(negedge clk);
    call = '0;
    chk("pass_dir_flip", 32'(dir_up_o), 32'h1);
    repeat (6) @(negedge clk);
    call = 4'b0100;
    @(negedge clk);
    call = '0;
    wait_drain("pass_stop");

    // idle at-floor call together with the next floor up
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset("rst_again");
    call = 4'b0011;
    exp_q.push_back(mk_exp(4'b0010, 0, 10, 1));
    exp_q.push_back(mk_exp(0, 1, 10, 1));
    @(negedge clk);
    call = '0;
    chk("atfloor_pending", 32'(pending_o), 32'h2);
    chk("atfloor_open", 32'(open_o), 32'h1);
    wait_drain("at_floor");

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
